// File: rtl/timer_apb_regs_if.sv
// APB3 bus bundle for the timer register block: master drives the request,
// slave returns read data, ready and error.
interface timer_apb_regs_if;
  logic       PSEL;
  logic       PENABLE;
  logic       PWRITE;
  logic [7:0] PADDR;
  logic [7:0] PWDATA;
  logic [7:0] PRDATA;
  logic       PREADY;
  logic       PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/timer_apb_regs.sv
// APB3 register file (TDR/TCR/TSR/CNT) and prescaler for the 8-bit timer,
// with overflow/underflow flag detection and a registered interrupt.
module timer_apb_regs #(
  parameter int         DIV_WIDTH = 4,
  parameter logic [7:0] RESET_TDR = 8'h00
) (
  input  logic               PCLK,
  input  logic               PRESETn,
  timer_apb_regs_if.slave    apb,
  input  logic [7:0]         COUNT,
  output logic               CLK_IN,
  output logic [7:0]         register_tcr,
  output logic [7:0]         register_tdr,
  output logic               clear_ovf,
  output logic               clear_udf,
  output logic               irq
);

  // Handshake: a transfer is the setup cycle (PSEL & !PENABLE) followed by the
  // access cycle (PSEL & PENABLE); PREADY is always 1, so writes commit on the
  // edge that ends the access cycle and read data is valid during it.
  localparam logic [7:0] ADDR_TDR = 8'h00;
  localparam logic [7:0] ADDR_TCR = 8'h01;
  localparam logic [7:0] ADDR_TSR = 8'h02;
  localparam logic [7:0] ADDR_CNT = 8'h03;

  logic [7:0]           tdr_q;
  logic [7:0]           tcr_q, tcr_d;
  logic [1:0]           tsr_q, tsr_d;
  logic [DIV_WIDTH-1:0] div_q;
  logic                 clk_in_q;
  logic [7:0]           prev_count_q;
  logic                 was_load_q;
  logic                 clear_ovf_q, clear_udf_q;
  logic                 irq_q;

  logic access, addr_ok, wr;
  logic wr_tdr, wr_tcr, wr_tsr;
  logic ovf_set, udf_set;
  logic clr_ovf, clr_udf;

  assign access  = apb.PSEL & apb.PENABLE;
  assign addr_ok = (apb.PADDR <= ADDR_CNT);
  assign wr      = access & apb.PWRITE & addr_ok;
  assign wr_tdr  = wr & (apb.PADDR == ADDR_TDR);
  assign wr_tcr  = wr & (apb.PADDR == ADDR_TCR);
  assign wr_tsr  = wr & (apb.PADDR == ADDR_TSR);

  assign clr_ovf = wr_tsr & apb.PWDATA[0];
  assign clr_udf = wr_tsr & apb.PWDATA[1];

  // Wrap detection is masked the cycle after a LOAD so reloading 0x00/0xFF
  // cannot be mistaken for a count wrap.
  assign ovf_set = (prev_count_q == 8'hFF) & (COUNT == 8'h00) &  tcr_q[5] & ~was_load_q;
  assign udf_set = (prev_count_q == 8'h00) & (COUNT == 8'hFF) & ~tcr_q[5] & ~was_load_q;

  always_comb begin
    tsr_d[0] = ovf_set | (tsr_q[0] & ~clr_ovf);
    tsr_d[1] = udf_set | (tsr_q[1] & ~clr_udf);
  end

  // LOAD self-clears unless a new TCR write lands on the same edge.
  always_comb begin
    tcr_d    = tcr_q;
    tcr_d[7] = 1'b0;
    if (wr_tcr) tcr_d = apb.PWDATA & 8'hBF;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      tdr_q        <= RESET_TDR;
      tcr_q        <= 8'h00;
      tsr_q        <= 2'b00;
      div_q        <= '0;
      clk_in_q     <= 1'b0;
      prev_count_q <= 8'h00;
      was_load_q   <= 1'b0;
      clear_ovf_q  <= 1'b0;
      clear_udf_q  <= 1'b0;
      irq_q        <= 1'b0;
    end else begin
      if (wr_tdr) tdr_q <= apb.PWDATA;
      tcr_q        <= tcr_d;
      tsr_q        <= tsr_d;
      div_q        <= div_q + DIV_WIDTH'(1);
      clk_in_q     <= div_q[tcr_q[1:0]];
      prev_count_q <= COUNT;
      was_load_q   <= tcr_q[7];
      clear_ovf_q  <= clr_ovf;
      clear_udf_q  <= clr_udf;
      irq_q        <= (tsr_q[0] & tcr_q[2]) | (tsr_q[1] & tcr_q[3]);
    end
  end

  always_comb begin
    apb.PRDATA = 8'h00;
    if (apb.PSEL & ~apb.PWRITE) begin
      case (apb.PADDR)
        ADDR_TDR: apb.PRDATA = tdr_q;
        ADDR_TCR: apb.PRDATA = tcr_q;
        ADDR_TSR: apb.PRDATA = {6'b000000, tsr_q};
        ADDR_CNT: apb.PRDATA = COUNT;
        default:  apb.PRDATA = 8'h00;
      endcase
    end
  end

  assign apb.PREADY  = 1'b1;
  assign apb.PSLVERR = access & ~addr_ok;

  assign CLK_IN       = clk_in_q;
  assign register_tcr = tcr_q;
  assign register_tdr = tdr_q;
  assign clear_ovf    = clear_ovf_q;
  assign clear_udf    = clear_udf_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_timer_apb_regs.sv
// Directed bench for timer_apb_regs: APB access, LOAD pulse, prescaler,
// OVF/UDF flags, W1C, error response and asynchronous reset.
module tb_timer_apb_regs;

  logic       PCLK;
  logic       PRESETn;
  logic [7:0] COUNT;
  logic       CLK_IN;
  logic [7:0] register_tcr;
  logic [7:0] register_tdr;
  logic       clear_ovf;
  logic       clear_udf;
  logic       irq;

  int checks;
  int failures;

  timer_apb_regs_if apb();

  timer_apb_regs #(.DIV_WIDTH(4), .RESET_TDR(8'h00)) dut (
    .PCLK         (PCLK),
    .PRESETn      (PRESETn),
    .apb          (apb.slave),
    .COUNT        (COUNT),
    .CLK_IN       (CLK_IN),
    .register_tcr (register_tcr),
    .register_tdr (register_tdr),
    .clear_ovf    (clear_ovf),
    .clear_udf    (clear_udf),
    .irq          (irq)
  );

  // clock / reset
  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // driver tasks
  task automatic apb_write(input logic [7:0] addr, input logic [7:0] data);
    @(posedge PCLK); #1;
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b1;
    apb.PADDR = addr; apb.PWDATA = data;
    @(posedge PCLK); #1;
    apb.PENABLE = 1'b1;
    @(posedge PCLK); #1;
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] addr, output logic [7:0] data, output logic err);
    @(posedge PCLK); #1;
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0; apb.PADDR = addr;
    @(posedge PCLK); #1;
    apb.PENABLE = 1'b1;
    @(negedge PCLK);
    data = apb.PRDATA;
    err  = apb.PSLVERR;
    @(posedge PCLK); #1;
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    logic       e;
    logic [7:0] exp_rd [4];
    exp_rd[0] = 8'h00; exp_rd[1] = 8'h00; exp_rd[2] = 8'h00; exp_rd[3] = 8'h5A;
    PRESETn = 1'b0;
    COUNT = 8'h5A;
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
    apb.PADDR = 8'h00; apb.PWDATA = 8'h00;
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    checks++;
    if ({CLK_IN, irq, clear_ovf, clear_udf} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_outputs: got %b required 0000", {CLK_IN, irq, clear_ovf, clear_udf});
    end
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    for (int a = 0; a < 4; a++) begin
      apb_read(8'(a), d, e);
      checks++;
      if (d !== exp_rd[a] || e !== 1'b0) begin
        failures++;
        $display("FAIL reset_read addr=%0d: got %h err=%b required %h err=0", a, d, e, exp_rd[a]);
      end
    end
  endtask

  task automatic test_tcr_load();
    logic [7:0] d;
    logic       e;
    COUNT = 8'h00;
    apb_write(8'h00, 8'hA5);
    checks++;
    if (register_tdr !== 8'hA5) begin
      failures++;
      $display("FAIL tdr_out: got %h required a5", register_tdr);
    end
    apb_write(8'h01, 8'h7F);
    apb_read(8'h01, d, e);
    checks++;
    if (d !== 8'h3F) begin
      failures++;
      $display("FAIL tcr_reserved: got %h required 3f", d);
    end
    apb_write(8'h01, 8'h96);
    @(negedge PCLK);
    checks++;
    if (register_tcr !== 8'h96) begin
      failures++;
      $display("FAIL load_pulse_high: got %h required 96", register_tcr);
    end
    @(negedge PCLK);
    checks++;
    if (register_tcr !== 8'h16) begin
      failures++;
      $display("FAIL load_pulse_clear: got %h required 16", register_tcr);
    end
    apb_read(8'h01, d, e);
    checks++;
    if (d !== 8'h16) begin
      failures++;
      $display("FAIL tcr_readback: got %h required 16", d);
    end
  endtask

  task automatic test_prescaler(input logic [1:0] cks, input int exp_period);
    int   first;
    int   second;
    int   high;
    logic prev;
    first = -1; second = -1; high = 0;
    apb_write(8'h01, {6'b000100, cks});
    repeat (3) @(negedge PCLK);
    prev = CLK_IN;
    for (int i = 0; i < 48; i++) begin
      @(negedge PCLK);
      if (!prev && CLK_IN) begin
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end
      if (first >= 0 && second < 0 && CLK_IN) high++;
      prev = CLK_IN;
    end
    checks++;
    if (second < 0 || (second - first) != exp_period) begin
      failures++;
      $display("FAIL clk_in_period cks=%0d: got %0d required %0d", cks, second - first, exp_period);
    end
    checks++;
    if (high != exp_period / 2) begin
      failures++;
      $display("FAIL clk_in_duty cks=%0d: got high=%0d required %0d", cks, high, exp_period / 2);
    end
  endtask

  task automatic test_ovf();
    logic [7:0] d;
    logic       e;
    apb_write(8'h01, 8'h24);
    @(posedge PCLK); #1 COUNT = 8'hFE;
    @(posedge PCLK); #1 COUNT = 8'hFF;
    @(posedge PCLK); #1 COUNT = 8'h00;
    @(posedge PCLK);
    @(negedge PCLK);
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL ovf_irq_lag: got %b required 0", irq);
    end
    @(negedge PCLK);
    checks++;
    if (irq !== 1'b1) begin
      failures++;
      $display("FAIL ovf_irq: got %b required 1", irq);
    end
    apb_read(8'h02, d, e);
    checks++;
    if (d !== 8'h01) begin
      failures++;
      $display("FAIL ovf_flag: got %h required 01", d);
    end
    apb_write(8'h02, 8'h00);
    apb_read(8'h02, d, e);
    checks++;
    if (d !== 8'h01) begin
      failures++;
      $display("FAIL w0_no_effect: got %h required 01", d);
    end
    apb_write(8'h02, 8'h01);
    @(negedge PCLK);
    checks++;
    if (clear_ovf !== 1'b1 || clear_udf !== 1'b0) begin
      failures++;
      $display("FAIL clear_ovf_pulse: got ovf=%b udf=%b required 1 0", clear_ovf, clear_udf);
    end
    @(negedge PCLK);
    checks++;
    if (clear_ovf !== 1'b0 || irq !== 1'b0) begin
      failures++;
      $display("FAIL clear_ovf_end: got clr=%b irq=%b required 0 0", clear_ovf, irq);
    end
    apb_read(8'h02, d, e);
    checks++;
    if (d !== 8'h00) begin
      failures++;
      $display("FAIL ovf_cleared: got %h required 00", d);
    end
  endtask

  task automatic test_udf();
    logic [7:0] d;
    logic       e;
    int         irq_seen;
    irq_seen = 0;
    apb_write(8'h01, 8'h00);
    @(posedge PCLK); #1 COUNT = 8'hFF;
    repeat (4) begin
      @(negedge PCLK);
      if (irq !== 1'b0) irq_seen++;
    end
    checks++;
    if (irq_seen != 0) begin
      failures++;
      $display("FAIL udf_irq_masked: got %0d irq cycles required 0", irq_seen);
    end
    apb_read(8'h02, d, e);
    checks++;
    if (d !== 8'h02) begin
      failures++;
      $display("FAIL udf_flag: got %h required 02", d);
    end
    apb_write(8'h01, 8'h08);
    @(negedge PCLK);
    @(negedge PCLK);
    checks++;
    if (irq !== 1'b1) begin
      failures++;
      $display("FAIL udf_irq_enabled: got %b required 1", irq);
    end
    apb_write(8'h02, 8'h02);
    @(negedge PCLK);
    checks++;
    if (clear_udf !== 1'b1 || clear_ovf !== 1'b0) begin
      failures++;
      $display("FAIL clear_udf_pulse: got udf=%b ovf=%b required 1 0", clear_udf, clear_ovf);
    end
    @(negedge PCLK);
    checks++;
    if (clear_udf !== 1'b0 || irq !== 1'b0) begin
      failures++;
      $display("FAIL clear_udf_end: got clr=%b irq=%b required 0 0", clear_udf, irq);
    end
  endtask

  task automatic test_load_no_flag();
    logic [7:0] d;
    logic       e;
    apb_write(8'h01, 8'h00);
    apb_write(8'h00, 8'hFF);
    @(posedge PCLK); #1 COUNT = 8'h00;
    repeat (2) @(posedge PCLK);
    apb_write(8'h01, 8'h80);
    @(posedge PCLK); #1 COUNT = 8'hFF;
    repeat (3) @(posedge PCLK);
    apb_read(8'h02, d, e);
    checks++;
    if (d !== 8'h00) begin
      failures++;
      $display("FAIL load_no_flag: got %h required 00", d);
    end
  endtask

  task automatic test_set_wins();
    logic [7:0] d;
    logic       e;
    apb_write(8'h01, 8'h20);
    @(posedge PCLK); #1 COUNT = 8'h00;
    repeat (2) @(posedge PCLK);
    #1 COUNT = 8'hFF;
    @(posedge PCLK); #1;
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b1;
    apb.PADDR = 8'h02; apb.PWDATA = 8'h01;
    @(posedge PCLK); #1;
    apb.PENABLE = 1'b1;
    COUNT = 8'h00;
    @(posedge PCLK); #1;
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
    @(negedge PCLK);
    checks++;
    if (clear_ovf !== 1'b1) begin
      failures++;
      $display("FAIL set_wins_pulse: got %b required 1", clear_ovf);
    end
    apb_read(8'h02, d, e);
    checks++;
    if (d !== 8'h01) begin
      failures++;
      $display("FAIL set_wins_flag: got %h required 01", d);
    end
    apb_write(8'h02, 8'h01);
    apb_read(8'h02, d, e);
    checks++;
    if (d !== 8'h00) begin
      failures++;
      $display("FAIL set_wins_cleanup: got %h required 00", d);
    end
  endtask

  task automatic test_slverr();
    logic [7:0] d;
    logic       e;
    logic [7:0] exp_rd [4];
    exp_rd[0] = 8'hFF; exp_rd[1] = 8'h20; exp_rd[2] = 8'h00; exp_rd[3] = 8'h00;
    @(posedge PCLK); #1;
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b1;
    apb.PADDR = 8'h10; apb.PWDATA = 8'h00;
    @(negedge PCLK);
    checks++;
    if (apb.PSLVERR !== 1'b0) begin
      failures++;
      $display("FAIL slverr_setup: got %b required 0", apb.PSLVERR);
    end
    @(posedge PCLK); #1;
    apb.PENABLE = 1'b1;
    @(negedge PCLK);
    checks++;
    if (apb.PSLVERR !== 1'b1) begin
      failures++;
      $display("FAIL slverr_access: got %b required 1", apb.PSLVERR);
    end
    @(posedge PCLK); #1;
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
    apb_write(8'h03, 8'h77);
    for (int a = 0; a < 4; a++) begin
      apb_read(8'(a), d, e);
      checks++;
      if (d !== exp_rd[a] || e !== 1'b0) begin
        failures++;
        $display("FAIL bad_write_ignored addr=%0d: got %h err=%b required %h err=0", a, d, e, exp_rd[a]);
      end
    end
    apb_read(8'h10, d, e);
    checks++;
    if (d !== 8'h00 || e !== 1'b1) begin
      failures++;
      $display("FAIL unmapped_read: got %h err=%b required 00 err=1", d, e);
    end
  endtask

  task automatic test_reset_mid_access();
    logic [7:0] d;
    logic       e;
    @(posedge PCLK); #1;
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b1;
    apb.PADDR = 8'h00; apb.PWDATA = 8'h33;
    @(posedge PCLK); #1;
    apb.PENABLE = 1'b1;
    @(negedge PCLK);
    PRESETn = 1'b0;
    #1;
    checks++;
    if (register_tdr !== 8'h00 || register_tcr !== 8'h00) begin
      failures++;
      $display("FAIL reset_mid_regs: got tdr=%h tcr=%h required 00 00", register_tdr, register_tcr);
    end
    checks++;
    if ({CLK_IN, irq, clear_ovf, clear_udf, apb.PSLVERR} !== 5'b00000 || apb.PRDATA !== 8'h00) begin
      failures++;
      $display("FAIL reset_mid_outs: got %b prdata=%h required 00000 prdata=00",
               {CLK_IN, irq, clear_ovf, clear_udf, apb.PSLVERR}, apb.PRDATA);
    end
    @(posedge PCLK); #1;
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
    PRESETn = 1'b1;
    apb_read(8'h00, d, e);
    checks++;
    if (d !== 8'h00) begin
      failures++;
      $display("FAIL reset_mid_lost: got %h required 00", d);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_tcr_load();
    test_prescaler(2'd2, 8);
    test_prescaler(2'd0, 2);
    test_prescaler(2'd3, 16);
    test_ovf();
    test_udf();
    test_load_no_flag();
    test_set_wins();
    test_slverr();
    test_reset_mid_access();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/timer_apb_regs.md
Name: timer_apb_regs

Overview:
APB3 slave register file and clock-prescaler stage sitting directly upstream of the 8-bit timer counter. Holds TDR (reload data), TCR (control) and TSR (status). Generates the counter's sampling clock CLK_IN from PCLK. Watches the counter value COUNT for overflow/underflow, sets sticky flags and raises an interrupt.

Parameters:
DIV_WIDTH, 4, width of the free-running prescaler counter; fixes the maximum divide ratio at PCLK/16.
RESET_TDR, 8'h00, reset value of TDR.

Ports:
PCLK  in  1  APB clock; all logic synchronous to it
PRESETn  in  1  asynchronous active-low reset
PSEL  in  1  APB select
PENABLE  in  1  APB access phase
PWRITE  in  1  1 = write, 0 = read
PADDR  in  8  register address
PWDATA  in  8  write data
PRDATA  out  8  read data
PREADY  out  1  tied 1 (zero wait state)
PSLVERR  out  1  error on unmapped address
COUNT  in  8  current counter value from the timer counter
CLK_IN  out  1  prescaled count clock to the timer counter
register_tcr  out  8  TCR contents to the timer counter
register_tdr  out  8  TDR contents to the timer counter
clear_ovf  out  1  one-cycle pulse when software clears the OVF flag
clear_udf  out  1  one-cycle pulse when software clears the UDF flag
irq  out  1  level interrupt

Behaviour:
- Reset is PRESETn, asynchronous, active-low. The clock is PCLK.
- Reset values: TDR = RESET_TDR; TCR = 0; TSR = 0; prescaler = 0; CLK_IN = 0; PSLVERR = 0; clear_ovf = 0; clear_udf = 0; irq = 0; PRDATA = 0; prev_count = 0.
- Address map:
  - 0x00 TDR: R/W.
  - 0x01 TCR: R/W.
  - 0x02 TSR: R/W1C. Bit0 = OVF, bit1 = UDF, other bits read 0.
  - 0x03 CNT: read-only, returns COUNT. Writes to CNT are ignored, no error.
- TCR bits:
  - [7] LOAD
  - [6] reserved, reads 0
  - [5] UP (1 = count up, 0 = count down)
  - [4] EN
  - [3] UDFIE
  - [2] OVFIE
  - [1:0] CKS
- APB write:
  - Committed on the PCLK edge where PSEL & PENABLE & PWRITE are all 1.
  - The setup phase (PENABLE = 0) has no effect.
- APB read:
  - PRDATA is combinational while PSEL & !PWRITE; it is 0 otherwise.
  - Unmapped address reads 0.
- PSLVERR:
  - Asserts combinationally during the access phase (PSEL & PENABLE) when PADDR > 0x03.
  - Such a write has no effect on any register.
- LOAD is self-clearing:
  - A write with bit7 = 1 sets TCR[7] for exactly one PCLK cycle.
  - Hardware clears it on the next edge; other TCR bits keep the written value.
  - A write arriving in the same cycle as the clear wins.
- Prescaler:
  - DIV_WIDTH-bit counter, free-running, increments every PCLK, wraps at all-ones.
  - CLK_IN is registered: CLK_IN <= div[CKS].
  - CKS 0/1/2/3 gives PCLK/2, /4, /8, /16, 50% duty.
  - Changing CKS takes effect on the next edge; a glitch-width change is acceptable because the counter edge-detects synchronously.
- Flag detection: prev_count <= COUNT every cycle. Let was_load = TCR[7] was 1 in the previous cycle.
  - OVF set when prev_count == 8'hFF, COUNT == 8'h00, TCR[5] = 1 and !was_load.
  - UDF set when prev_count == 8'h00, COUNT == 8'hFF, TCR[5] = 0 and !was_load.
  - A load of 0x00 or 0xFF never sets a flag.
- W1C:
  - Writing 1 to TSR bit0 clears OVF and pulses clear_ovf for one cycle. Bit1 does the same for UDF / clear_udf.
  - Writing 0 has no effect.
  - Simultaneous hardware set and software clear: the set wins (flag stays 1) and the clear pulse is still emitted.
- irq is registered: irq <= (OVF & OVFIE) | (UDF & UDFIE). It is one cycle behind the flag.
- Reset mid-transfer: all state returns to reset values immediately; the transfer in progress is lost.

Test Plan:
- Reset, then read 0x00–0x03 -> TDR = 00, TCR = 00, TSR = 00, CNT = COUNT; PSLVERR = 0.
- Write TDR = 0xA5, TCR = 0x96 (LOAD|EN|OVFIE|CKS=2), read TCR next -> TCR[7] high for one cycle only; read back 0x16; register_tdr = 0xA5; CLK_IN period 8 PCLK.
- Drive COUNT 0xFE→0xFF→0x00 with UP=1 -> TSR = 0x01 the cycle after the wrap; irq = 1 the following cycle; write TSR = 0x01 -> OVF = 0, clear_ovf pulses once, irq drops.
- UP = 0, COUNT 0x00→0xFF -> UDF set; with UDFIE = 0, irq stays 0. Load of 0xFF with LOAD pulse and COUNT 0x00→0xFF -> no flag.
- Same-cycle OVF set and W1C of bit0 -> OVF remains 1, clear_ovf pulses.
- Write to PADDR = 0x10 -> PSLVERR = 1 in the access phase; all registers unchanged. Assert PRESETn low mid-access -> all outputs at reset values.
